// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one synchronous single-port memory
// between instruction fetch (port I, read-only) and load/store (port D).
module mem_arbiter #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [BIT_WIDTH-1:0] i_addr,
    output logic                 i_ack,
    output logic [BIT_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BIT_WIDTH-1:0] d_addr,
    input  logic [BIT_WIDTH-1:0] d_wdata,
    output logic                 d_ack,
    output logic [BIT_WIDTH-1:0] d_rdata,
    output logic [BIT_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [BIT_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t               state, state_nxt;
    port_t                cur_port, last_grant, grant;
    logic                 grant_vld;
    logic                 latched_we;
    logic [BIT_WIDTH-1:0] i_rdata_q, d_rdata_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        grant_vld = 1'b0;
        grant     = PORT_I;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        mem_we    = 1'b0;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_vld = 1'b1;
                    if (i_req && d_req) grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
                    else                grant = i_req ? PORT_I : PORT_D;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Gated by rst_n so a reset edge can never coincide with a memory write.
                mem_we    = latched_we & rst_n;
                state_nxt = RESP;
            end
            RESP: begin
                // Only the port not just served may be granted back-to-back.
                grant     = (cur_port == PORT_I) ? PORT_D : PORT_I;
                grant_vld = (cur_port == PORT_I) ? d_req : i_req;
                state_nxt = grant_vld ? BUSY : IDLE;
                if (cur_port == PORT_I) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_rdata;
                end else begin
                    d_ack = 1'b1;
                    if (!latched_we) d_rdata = mem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is bypassed from the memory in the ack cycle and captured here so it
    // holds until that port's next access.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            cur_port   <= PORT_I;
            last_grant <= PORT_D;
            latched_we <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP) begin
                if (cur_port == PORT_I)  i_rdata_q <= mem_rdata;
                else if (!latched_we)    d_rdata_q <= mem_rdata;
            end
            if (grant_vld) begin
                cur_port   <= grant;
                last_grant <= grant;
                if (grant == PORT_I) begin
                    mem_addr   <= i_addr;
                    latched_we <= 1'b0;
                end else begin
                    mem_addr   <= d_addr;
                    mem_wdata  <= d_wdata;
                    latched_we <= d_we;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory plus a reference model that
// predicts each port's read data in issue order; a negedge monitor compares on every ack.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_req, i_ack, d_req, d_we, d_ack, mem_we;
    logic [W-1:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [W-1:0] mem_rdata = '0;

    mem_arbiter #(.BIT_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           we;
        logic [W-1:0] data;
    } d_exp_t;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } st_exp_t;

    bit [31:0]    mem_arr [bit [31:0]];
    bit [31:0]    ref_mem [bit [31:0]];
    logic [W-1:0] i_q [$];
    d_exp_t       d_q [$];
    st_exp_t      st_q [$];
    bit           ack_log [$];
    bit           log_en = 1'b0;
    logic [W-1:0] i_last = '0;
    logic [W-1:0] d_last = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
        return (a * 32'h0101_0101) ^ 32'hC3C3_0000;
    endfunction

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Fetch region 100..115 (plus 3); data region 4..35. They never overlap, so fetch
    // results do not depend on how I and D interleave.
    function automatic logic [W-1:0] rand_i();
        return W'($urandom_range(100, 115));
    endfunction

    function automatic logic [W-1:0] rand_d();
        return W'($urandom_range(4, 35));
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: registered read, write-through without updating read data.
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else        mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
    end

    // Monitor
    d_exp_t  mon_d;
    st_exp_t mon_s;
    always @(negedge clk) begin
        if (i_ack) begin
            check("dual_ack", d_ack, 0);
            if (i_q.size() == 0) check("i_spurious_ack", i_ack, 0);
            else check("i_rdata", i_rdata, i_q.pop_front());
            if (log_en) ack_log.push_back(1'b0);
        end
        if (d_ack) begin
            if (d_q.size() == 0) check("d_spurious_ack", d_ack, 0);
            else begin
                mon_d = d_q.pop_front();
                check(mon_d.we ? "d_rdata_store_hold" : "d_rdata", d_rdata, mon_d.data);
            end
            if (log_en) ack_log.push_back(1'b1);
        end
        if (mem_we) begin
            if (st_q.size() == 0) check("spurious_write", mem_we, 0);
            else begin
                mon_s = st_q.pop_front();
                check("write_addr", mem_addr, mon_s.addr);
                check("write_data", mem_wdata, mon_s.data);
            end
        end
    end

    task automatic do_i(input logic [W-1:0] a, output int lat);
        i_addr = a;
        i_req  = 1'b1;
        i_last = ref_rd(a);
        i_q.push_back(i_last);
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (i_ack) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("i_ack_timeout", i_ack, 1);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic do_d(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd,
                        output int lat, output int nwe, output int we_cyc);
        d_exp_t  e;
        st_exp_t s;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (we) begin
            ref_mem[a] = wd;
            s.addr = a;
            s.data = wd;
            st_q.push_back(s);
        end else begin
            d_last = ref_rd(a);
        end
        e.we   = we;
        e.data = d_last;
        d_q.push_back(e);
        lat    = -1;
        nwe    = 0;
        we_cyc = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                we_cyc = c;
            end
            if (d_ack) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("d_ack_timeout", d_ack, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int     lat, nwe, wcyc;
        d_exp_t e;

        mem_arr[3] = 32'h11;    ref_mem[3] = 32'h11;
        mem_arr[7] = 32'h77;    ref_mem[7] = 32'h77;
        mem_arr[9] = 32'h0;     ref_mem[9] = 32'h0;
        mem_arr[100] = 32'hABCD; ref_mem[100] = 32'hABCD;

        // Reset held two cycles with both ports requesting
        rst_n = 1'b0; i_req = 1'b1; i_addr = 3; d_req = 1'b1; d_we = 1'b0; d_addr = 7; d_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_i_ack", i_ack, 0);
            check("rst_d_ack", d_ack, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_i_rdata", i_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            check("rst_mem_addr", mem_addr, 0);
        end

        // Release: cycle 0 is IDLE with both requests; I must win the first conflict
        rst_n  = 1'b1;
        i_last = ref_rd(3);
        i_q.push_back(i_last);
        d_last = ref_rd(7);
        e.we   = 1'b0;
        e.data = d_last;
        d_q.push_back(e);
        @(negedge clk);
        check("c1_mem_addr_i", mem_addr, 3);
        check("c1_i_ack", i_ack, 0);
        @(negedge clk);
        check("c2_i_ack", i_ack, 1);
        check("c2_d_ack", d_ack, 0);
        @(posedge clk); #1; i_req = 1'b0;
        @(negedge clk);
        check("c3_mem_addr_d", mem_addr, 7);
        check("c3_d_ack", d_ack, 0);
        @(negedge clk);
        check("c4_d_ack", d_ack, 1);
        @(posedge clk); #1; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single store then load of the same word
        do_d(1'b1, 5, 32'hDEADBEEF, lat, nwe, wcyc);
        check("st_we_cycles", nwe, 1);
        check("st_ack_after_we", lat - wcyc, 1);
        check("st_latency", lat, 2);
        do_d(1'b0, 5, '0, lat, nwe, wcyc);
        check("ld_latency", lat, 2);
        check("ld_we_cycles", nwe, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset during BUSY of a store: write and ack must be dropped
        d_we = 1'b1; d_addr = 9; d_wdata = 32'hBADC0DE0; d_req = 1'b1;
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        check("rstbusy_mem_addr", mem_addr, 9);
        check("rstbusy_mem_we", mem_we, 0);
        check("rstbusy_d_ack", d_ack, 0);
        @(posedge clk); #1; d_req = 1'b0; rst_n = 1'b1; d_last = '0; i_last = '0;
        @(negedge clk);
        check("rstbusy_no_late_ack", d_ack, 0);
        check("rstbusy_d_rdata", d_rdata, 0);
        check("rstbusy_i_rdata", i_rdata, 0);
        @(posedge clk); #1;
        do_d(1'b0, 9, '0, lat, nwe, wcyc);

        // Idle hold after a fetch
        do_i(100, lat);
        check("fetch_latency", lat, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_i_rdata", i_rdata, 32'hABCD);
            check("idle_acks", {i_ack, d_ack}, 0);
            check("idle_mem_we", mem_we, 0);
        end
        @(posedge clk); #1;

        // Round-robin fairness: both ports reassert immediately after each ack
        log_en = 1'b1;
        fork
            begin
                int l;
                for (int k = 0; k < 4; k++) begin
                    do_i(rand_i(), l);
                    check("rr_i_wait", l <= 4, 1);
                end
            end
            begin
                int l, n, wc;
                for (int k = 0; k < 4; k++) begin
                    do_d(1'($urandom_range(0, 1)), rand_d(), $urandom, l, n, wc);
                    check("rr_d_wait", l <= 4, 1);
                end
            end
        join
        log_en = 1'b0;
        check("rr_count", ack_log.size(), 8);
        for (int k = 1; k < ack_log.size(); k++)
            check("rr_alternate", ack_log[k] != ack_log[k-1], 1);
        repeat (2) @(posedge clk);
        #1;

        // Random traffic with random gaps on both ports
        fork
            begin
                int l;
                for (int k = 0; k < 40; k++) begin
                    do_i(rand_i(), l);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                int l, n, wc;
                for (int k = 0; k < 40; k++) begin
                    do_d(1'($urandom_range(0, 1)), rand_d(), $urandom, l, n, wc);
                    check("rand_d_we_cycles", n, (d_we ? 1 : 0));
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join

        repeat (4) @(negedge clk);
        check("i_q_drained", i_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);
        check("st_q_drained", st_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
